hilo_unit: RTL and testbench

- HI/LO architectural register pair with an iterative 32-bit divider, sitting directly beside and downstream of the execute stage.
- Consumes execute-stage results: MULT/MULTU products, MTHI/MTLO data, and DIV/DIVU operands.
- Feeds current HI/LO back to execute for MFHI/MFLO.
- Raises a busy/stall signal while a divide is in flight.

---
 rtl/hilo_unit_if.sv | 32 +++
 rtl/hilo_unit.sv | 136 +++++++++++++
 tb/tb_hilo_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: execute-stage writes and divide requests in, HI/LO and divider status out.
// The master drives requests and must stall on div_busy; the slave is the hilo_unit itself.
interface hilo_unit_if #(
  parameter int DW = 32
);
  logic          flush;
  logic          write_hilo;
  logic          write_hi;
  logic          write_lo;
  logic [DW-1:0] hi_in;
  logic [DW-1:0] lo_in;
  logic          div_start;
  logic          div_signed;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          div_busy;
  logic          div_done;

  modport master (
    output flush, write_hilo, write_hi, write_lo, hi_in, lo_in,
    output div_start, div_signed, dividend, divisor,
    input  hi, lo, div_busy, div_done
  );

  modport slave (
    input  flush, write_hilo, write_hi, write_lo, hi_in, lo_in,
    input  div_start, div_signed, dividend, divisor,
    output hi, lo, div_busy, div_done
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair with 32-step restoring divider; HILO_BYPASS_EN forwards same-cycle writes to hi/lo.
// div_done pulses 34 cycles after div_start is taken; div_busy stalls upstream and starts while busy are dropped.
module hilo_unit #(
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       resetn,
  hilo_unit_if.slave bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] dvsr_q, dvsr_d;
  logic [DW-1:0] raw_q, raw_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          done_q, done_d;

  logic [DW:0]   shift_a;
  logic [DW+1:0] trial;
  logic          no_borrow;
  logic          fix_wr;
  logic [DW-1:0] fix_hi, fix_lo;
  logic [DW-1:0] dvd_abs, dvs_abs;

  assign dvd_abs = (bus.div_signed && bus.dividend[DW-1]) ? -bus.dividend : bus.dividend;
  assign dvs_abs = (bus.div_signed && bus.divisor[DW-1])  ? -bus.divisor  : bus.divisor;

  // {rem,quo} shifted left one place; the extra top bits catch the borrow of the trial subtract
  assign shift_a   = {rem_q, quo_q[DW-1]};
  assign trial     = {1'b0, shift_a} - {2'b00, dvsr_q};
  assign no_borrow = ~trial[DW+1];

  // A zero divisor leaves the quotient all ones naturally, but the signed fix-up must not touch it
  assign fix_lo = (dvsr_q == '0) ? '1    : (qneg_q ? -quo_q : quo_q);
  assign fix_hi = (dvsr_q == '0) ? raw_q : (rneg_q ? -rem_q : rem_q);
  assign fix_wr = (state_q == FIX) && !bus.flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    raw_d   = raw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (bus.write_hilo) begin
      hi_d = bus.hi_in;
      lo_d = bus.lo_in;
    end else begin
      if (bus.write_hi) hi_d = bus.hi_in;
      if (bus.write_lo) lo_d = bus.lo_in;
    end
    if (fix_wr) begin
      hi_d   = fix_hi;
      lo_d   = fix_lo;
      done_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.div_start) begin
          state_d = CALC;
          qneg_d  = bus.div_signed & (bus.dividend[DW-1] ^ bus.divisor[DW-1]);
          rneg_d  = bus.div_signed & bus.dividend[DW-1];
          quo_d   = dvd_abs;
          dvsr_d  = dvs_abs;
          raw_d   = bus.dividend;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        rem_d = no_borrow ? trial[DW-1:0] : shift_a[DW-1:0];
        quo_d = {quo_q[DW-2:0], no_borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      raw_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      raw_q   <= raw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef HILO_BYPASS_EN
  assign bus.hi = hi_d;
  assign bus.lo = lo_d;
`else
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
`endif
  assign bus.div_busy = (state_q != IDLE);
  assign bus.div_done = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed and randomized checks of hilo_unit against a plain-arithmetic divide/register model.
module tb_hilo_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_unit_if #(.DW(32)) bus ();

  hilo_unit #(.DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (!sgn) begin
      el = a / b;
      eh = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      el = a;
      eh = 32'd0;
    end else begin
      el = 32'($signed(a) / $signed(b));
      eh = 32'($signed(a) % $signed(b));
    end
  endfunction

  // Start a divide in the current cycle (cycle 0) and follow it to cycle 35.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input bit clash);
    bit bad = 1'b0;
    bus.div_start  = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    tick();
    bus.div_start = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    for (int c = 1; c <= 33; c++) begin
      if (!(bus.div_busy === 1'b1 && bus.div_done === 1'b0)) bad = 1'b1;
      bus.div_start = (c == 5);
      bus.div_signed = (c == 5) ? ~sgn : sgn;
      if (c == 33 && clash) begin
        bus.write_hilo = 1'b1;
        bus.hi_in      = 32'hDEAD_0001;
        bus.lo_in      = 32'hBEEF_0002;
      end
`ifdef HILO_BYPASS_EN
      if (c == 33) begin
        #1;
        chk({tag, " fix bypass hi"}, bus.hi, eh);
        chk({tag, " fix bypass lo"}, bus.lo, el);
      end
`endif
      tick();
    end
    bus.write_hilo = 1'b0;
    chk({tag, " busy/done 1..33"}, 32'(bad), 32'd0);
    chk({tag, " done c34"}, 32'(bus.div_done), 32'd1);
    chk({tag, " busy c34"}, 32'(bus.div_busy), 32'd0);
    chk({tag, " hi"}, bus.hi, eh);
    chk({tag, " lo"}, bus.lo, el);
    tick();
    chk({tag, " done c35"}, 32'(bus.div_done), 32'd0);
    chk({tag, " busy c35"}, 32'(bus.div_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] eh, el, a, b, h0, l0;
    logic        sgn;
    bit          seen;

    bus.flush = 1'b0;   bus.write_hilo = 1'b0; bus.write_hi = 1'b0; bus.write_lo = 1'b0;
    bus.hi_in = '0;     bus.lo_in = '0;        bus.div_start = 1'b0; bus.div_signed = 1'b0;
    bus.dividend = '0;  bus.divisor = '0;

    // Reset values
    tick();
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy", 32'(bus.div_busy), 32'd0);
    chk("reset done", 32'(bus.div_done), 32'd0);
    resetn = 1'b1;
    tick();

    // MULT-style write with write_hi also raised: both registers take the pair
    bus.write_hilo = 1'b1; bus.write_hi = 1'b1;
    bus.hi_in = 32'h1234_5678; bus.lo_in = 32'h9ABC_DEF0;
`ifdef HILO_BYPASS_EN
    #1;
    chk("mult bypass hi", bus.hi, 32'h1234_5678);
    chk("mult bypass lo", bus.lo, 32'h9ABC_DEF0);
`else
    #1;
    chk("mult same-cycle hi", bus.hi, 32'd0);
`endif
    tick();
    bus.write_hilo = 1'b0; bus.write_hi = 1'b0;
    chk("mult hi", bus.hi, 32'h1234_5678);
    chk("mult lo", bus.lo, 32'h9ABC_DEF0);

    // MTHI then MTLO touch only their own register
    bus.write_hi = 1'b1; bus.hi_in = 32'h0000_00A5; bus.lo_in = 32'h0000_DEAD;
`ifdef HILO_BYPASS_EN
    #1;
    chk("mthi bypass hi", bus.hi, 32'h0000_00A5);
`endif
    tick();
    bus.write_hi = 1'b0;
    chk("mthi hi", bus.hi, 32'h0000_00A5);
    chk("mthi lo kept", bus.lo, 32'h9ABC_DEF0);
    bus.write_lo = 1'b1; bus.hi_in = 32'h0000_BEEF; bus.lo_in = 32'h0000_005A;
    tick();
    bus.write_lo = 1'b0;
    chk("mtlo hi kept", bus.hi, 32'h0000_00A5);
    chk("mtlo lo", bus.lo, 32'h0000_005A);

    // Directed divides
    run_div("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_div("udiv 100/7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_div("udiv ffffffff/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_div("div0 0x55", 1'b0, 32'h55, 32'd0, 32'h55, 32'hFFFF_FFFF, 1'b0);
    run_div("sdiv0 neg", 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0);
    run_div("sdiv min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // Flush at cycle 10 aborts; a register write during the divide still lands
    bus.div_start = 1'b1; bus.div_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    tick();
    bus.div_start = 1'b0;
    for (int c = 1; c < 4; c++) tick();
    bus.write_hi = 1'b1; bus.hi_in = 32'hCAFE_0000;
    tick();
    bus.write_hi = 1'b0;
    chk("write during busy hi", bus.hi, 32'hCAFE_0000);
    h0 = bus.hi; l0 = bus.lo;
    for (int c = 5; c < 10; c++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush busy c11", 32'(bus.div_busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.div_done === 1'b1 || bus.div_busy === 1'b1) seen = 1'b1;
      tick();
    end
    chk("flush no done", 32'(seen), 32'd0);
    chk("flush hi kept", bus.hi, h0);
    chk("flush lo kept", bus.lo, l0);

    // Flush together with div_start: no start
    bus.flush = 1'b1; bus.div_start = 1'b1;
    tick();
    bus.flush = 1'b0; bus.div_start = 1'b0;
    chk("flush+start busy", 32'(bus.div_busy), 32'd0);

    // Asynchronous reset in the middle of CALC
    bus.div_start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd5;
    tick();
    bus.div_start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    resetn = 1'b0;
    #1;
    chk("midcalc reset hi", bus.hi, 32'd0);
    chk("midcalc reset lo", bus.lo, 32'd0);
    chk("midcalc reset busy", 32'(bus.div_busy), 32'd0);
    tick();
    resetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.div_done === 1'b1 || bus.div_busy === 1'b1) seen = 1'b1;
      tick();
    end
    chk("reset no done", 32'(seen), 32'd0);

    // Randomized divides, including zero and tiny divisors and FIX-cycle write clashes
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 3);
        1:       b = -($urandom_range(0, 9));
        default: b = $urandom;
      endcase
      if (i % 8 == 7) a = 32'h8000_0000;
      model(sgn, a, b, eh, el);
      run_div($sformatf("rand%0d", i), sgn, a, b, eh, el, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
